// File: rtl/alu_issue_ctrl.sv
// Single-issue controller for an external combinational ALU: owns the register
// file, sequences each instruction through operand read, execute and write-back.
module alu_issue_ctrl #(
    parameter int N    = 32,
    parameter int NREG = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [3:0]   instr_func,
    input  logic [3:0]   instr_rs,
    input  logic [3:0]   instr_rt,
    input  logic [3:0]   instr_rd,
    input  logic         instr_imm_en,
    input  logic [15:0]  instr_imm,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_func,
    input  logic [N-1:0] alu_res,
    output logic         wb_valid,
    output logic [3:0]   wb_rd,
    output logic [N-1:0] wb_data,
    output logic [15:0]  retired_cnt,
    input  logic [3:0]   dbg_raddr,
    output logic [N-1:0] dbg_rdata
);

    typedef enum logic [1:0] {IDLE, OPRD, EXEC, WB} state_t;

    state_t state, state_nxt;

    logic [N-1:0] rf [NREG];
    logic [3:0]   func_q, rs_q, rt_q, rd_q;
    logic         imm_en_q;
    logic [15:0]  imm_q;
    logic [N-1:0] alu_a_q, alu_b_q, result_q;
    logic [3:0]   alu_func_q;
    logic [15:0]  cnt_q;

    // R0 and any index beyond the implemented depth read as zero.
    function automatic logic [N-1:0] rf_read(input logic [3:0] idx);
        if (idx == 4'd0 || int'(idx) >= NREG)
            return '0;
        return rf[idx];
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = OPRD;
            OPRD:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            func_q     <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            imm_en_q   <= 1'b0;
            imm_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_func_q <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            // NOTE: the register file is architecturally cleared by reset, so it is
            // built from flops rather than a RAM macro that could not be reset.
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else begin
            case (state)
                IDLE: if (instr_valid) begin
                    func_q   <= instr_func;
                    rs_q     <= instr_rs;
                    rt_q     <= instr_rt;
                    rd_q     <= instr_rd;
                    imm_en_q <= instr_imm_en;
                    imm_q    <= instr_imm;
                end
                OPRD: begin
                    alu_a_q    <= rf_read(rs_q);
                    alu_b_q    <= imm_en_q ? {{(N-16){imm_q[15]}}, imm_q} : rf_read(rt_q);
                    alu_func_q <= func_q;
                end
                EXEC: result_q <= alu_res;
                WB: begin
                    if (rd_q != 4'd0 && int'(rd_q) < NREG)
                        rf[rd_q] <= result_q;
                    cnt_q <= cnt_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are forced low during reset even though state is already IDLE.
    assign instr_ready = (state == IDLE) && !rst;
    assign wb_valid    = (state == WB) && !rst;
    assign wb_rd       = rd_q;
    assign wb_data     = result_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_func    = alu_func_q;
    assign retired_cnt = cnt_q;
    assign dbg_rdata   = rf_read(dbg_raddr);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: table-driven instruction vectors, a
// write-back scoreboard, and hand-written backpressure, reset and wrap sequences.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_func, instr_rs, instr_rt, instr_rd;
    logic        instr_imm_en;
    logic [15:0] instr_imm;
    logic [31:0] alu_a, alu_b, alu_res;
    logic [3:0]  alu_func;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [15:0] retired_cnt;
    logic [3:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    alu_issue_ctrl #(.N(32), .NREG(16)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_func(instr_func), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .instr_rd(instr_rd), .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_res(alu_res),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .retired_cnt(retired_cnt), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // External ALU stand-in: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 15 LUI, others ADD.
    always_comb begin
        case (alu_func)
            4'd1:    alu_res = alu_a - alu_b;
            4'd2:    alu_res = alu_a & alu_b;
            4'd3:    alu_res = alu_a | alu_b;
            4'd4:    alu_res = alu_a ^ alu_b;
            4'd15:   alu_res = alu_b << 16;
            default: alu_res = alu_a + alu_b;
        endcase
    end

    typedef struct {
        logic [3:0]  func, rs, rt, rd;
        logic        imm_en;
        logic [15:0] imm;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        logic [3:0]  func;
        int          cyc;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every write-back must match the oldest outstanding instruction, three cycles after accept.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("wb_rd", {28'd0, wb_rd}, {28'd0, e.rd});
                check("wb_data", wb_data, e.data);
                check("wb_cycle", cyc, e.cyc);
                check("alu_func_hold", {28'd0, alu_func}, {28'd0, e.func});
            end
        end
    end

    task automatic drive(input vec_t v);
        instr_func   = v.func;
        instr_rs     = v.rs;
        instr_rt     = v.rt;
        instr_rd     = v.rd;
        instr_imm_en = v.imm_en;
        instr_imm    = v.imm;
    endtask

    task automatic issue(input vec_t v, input bit push);
        int waited = 0;
        @(negedge clk);
        while (!instr_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!instr_ready) begin
            check("issue_ready_timeout", 32'd0, 32'd1);
            return;
        end
        drive(v);
        instr_valid = 1'b1;
        if (push) sb.push_back('{rd: v.rd, data: v.exp, func: v.func, cyc: cyc + 3});
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((!instr_ready || sb.size() != 0) && n < 20);
        if (!instr_ready || sb.size() != 0) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic dbg_check(input string name, input logic [3:0] idx, input logic [31:0] exp);
        dbg_raddr = idx;
        #1 check(name, dbg_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        vec_t bp_a, bp_b;
        int   acc_cyc[2];
        int   n_acc;

        // Results chain through the register file, so the table order matters.
        tbl[0] = '{func: 4'd0,  rs: 4'd0, rt: 4'd0, rd: 4'd1, imm_en: 1'b1, imm: 16'h0005, exp: 32'h0000_0005};
        tbl[1] = '{func: 4'd0,  rs: 4'd0, rt: 4'd0, rd: 4'd2, imm_en: 1'b1, imm: 16'hFFFD, exp: 32'hFFFF_FFFD};
        tbl[2] = '{func: 4'd1,  rs: 4'd1, rt: 4'd2, rd: 4'd3, imm_en: 1'b0, imm: 16'h0000, exp: 32'h0000_0008};
        tbl[3] = '{func: 4'd0,  rs: 4'd0, rt: 4'd0, rd: 4'd0, imm_en: 1'b1, imm: 16'h0007, exp: 32'h0000_0007};
        tbl[4] = '{func: 4'd2,  rs: 4'd3, rt: 4'd0, rd: 4'd4, imm_en: 1'b1, imm: 16'h000C, exp: 32'h0000_0008};
        tbl[5] = '{func: 4'd3,  rs: 4'd1, rt: 4'd3, rd: 4'd5, imm_en: 1'b0, imm: 16'h0000, exp: 32'h0000_000D};
        tbl[6] = '{func: 4'd4,  rs: 4'd5, rt: 4'd2, rd: 4'd6, imm_en: 1'b0, imm: 16'h0000, exp: 32'hFFFF_FFF0};
        tbl[7] = '{func: 4'd15, rs: 4'd0, rt: 4'd0, rd: 4'd7, imm_en: 1'b1, imm: 16'h1234, exp: 32'h1234_0000};
        tbl[8] = '{func: 4'd9,  rs: 4'd7, rt: 4'd0, rd: 4'd8, imm_en: 1'b1, imm: 16'h8000, exp: 32'h1233_8000};

        rst = 1'b1;
        instr_valid = 1'b0;
        drive('{func: 4'd0, rs: 4'd0, rt: 4'd0, rd: 4'd0, imm_en: 1'b0, imm: 16'h0, exp: 32'h0});
        dbg_raddr = 4'd0;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, instr_ready}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_cnt", {16'd0, retired_cnt}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_func", {28'd0, alu_func}, 32'd0);
        check("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, instr_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            issue(tbl[i], 1'b1);
            wait_idle();
            if (i == 2) check("cnt_after_3", {16'd0, retired_cnt}, 32'd3);
        end
        check("cnt_after_table", {16'd0, retired_cnt}, 32'd9);
        dbg_check("rf1", 4'd1, 32'h0000_0005);
        dbg_check("rf0_after_wr", 4'd0, 32'h0000_0000);
        dbg_check("rf3", 4'd3, 32'h0000_0008);
        dbg_check("rf6", 4'd6, 32'hFFFF_FFF0);
        dbg_check("rf8", 4'd8, 32'h1233_8000);

        // Backpressure: valid held high across two back-to-back instructions.
        bp_a = '{func: 4'd0, rs: 4'd1, rt: 4'd0, rd: 4'd9,  imm_en: 1'b1, imm: 16'h0001, exp: 32'h0000_0006};
        bp_b = '{func: 4'd0, rs: 4'd9, rt: 4'd0, rd: 4'd10, imm_en: 1'b1, imm: 16'h0002, exp: 32'h0000_0008};
        n_acc = 0;
        @(negedge clk);
        drive(bp_a);
        instr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            if (instr_ready && instr_valid) begin
                acc_cyc[n_acc] = cyc;
                sb.push_back('{rd: (n_acc == 0) ? bp_a.rd : bp_b.rd,
                               data: (n_acc == 0) ? bp_a.exp : bp_b.exp,
                               func: 4'd0, cyc: cyc + 3});
                n_acc++;
                @(posedge clk);
                #1;
                if (n_acc == 1) drive(bp_b);
                else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        wait_idle();
        check("bp_accepts", n_acc, 32'd2);
        if (n_acc == 2) check("bp_spacing", acc_cyc[1] - acc_cyc[0], 32'd4);
        dbg_check("rf10", 4'd10, 32'h0000_0008);
        check("cnt_after_bp", {16'd0, retired_cnt}, 32'd11);

        // Reset during EXEC aborts the instruction and clears all state.
        issue('{func: 4'd0, rs: 4'd0, rt: 4'd0, rd: 4'd11, imm_en: 1'b1, imm: 16'h0055, exp: 32'h55}, 1'b0);
        @(negedge clk);
        check("ready_in_oprd", {31'd0, instr_ready}, 32'd0);
        @(negedge clk);
        check("ready_in_exec", {31'd0, instr_ready}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_ready", {31'd0, instr_ready}, 32'd0);
        check("midrst_cnt", {16'd0, retired_cnt}, 32'd0);
        for (int r = 0; r < 16; r++)
            dbg_check("midrst_rf", 4'(r), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", {31'd0, instr_ready}, 32'd1);
        repeat (4) @(negedge clk);
        dbg_check("midrst_rf11", 4'd11, 32'd0);
        check("midrst_cnt_after", {16'd0, retired_cnt}, 32'd0);

        // Counter wrap: preset near the top, then retire two instructions.
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        #1 release dut.cnt_q;
        issue('{func: 4'd0, rs: 4'd0, rt: 4'd0, rd: 4'd1, imm_en: 1'b1, imm: 16'h0001, exp: 32'h1}, 1'b1);
        wait_idle();
        check("cnt_ffff", {16'd0, retired_cnt}, 32'h0000_FFFF);
        issue('{func: 4'd0, rs: 4'd1, rt: 4'd0, rd: 4'd2, imm_en: 1'b1, imm: 16'h0001, exp: 32'h2}, 1'b1);
        wait_idle();
        check("cnt_wrap", {16'd0, retired_cnt}, 32'h0000_0000);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
